// File: rtl/arp_rx_cache.sv
// rtl/arp_rx_cache.sv - ARP payload parser with IP/MAC learning cache, reply request and MAC lookup
module arp_rx_cache #(
    parameter int CACHE_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           arp_tdata_in,
    input  logic                 arp_tvalid_in,
    input  logic                 arp_tlast_in,
    input  logic [31:0]          local_ip_addr,
    input  logic                 cache_clear_in,
    output logic                 reply_valid_out,
    input  logic                 reply_ready_in,
    output logic [31:0]          reply_ip_out,
    output logic [47:0]          reply_mac_out,
    input  logic                 lookup_req_in,
    input  logic [31:0]          lookup_ip_in,
    output logic                 lookup_valid_out,
    output logic                 lookup_hit_out,
    output logic [47:0]          lookup_mac_out,
    output logic [CNT_WIDTH-1:0] drop_cnt_out
);
    localparam int PTR_W = $clog2(CACHE_DEPTH);

    logic [5:0]             cnt_q;
    logic [15:0]            htype_q, ptype_q, oper_q;
    logic [7:0]             hlen_q, plen_q;
    logic [47:0]            sha_q;
    logic [31:0]            spa_q, tpa_q;
    logic                   commit_q, len_ok_q;

    logic [CACHE_DEPTH-1:0] valid_q;
    logic [31:0]            ip_q  [CACHE_DEPTH];
    logic [47:0]            mac_q [CACHE_DEPTH];
    logic [PTR_W-1:0]       rr_q;

    logic                   reply_valid_q;
    logic [31:0]            reply_ip_q;
    logic [47:0]            reply_mac_q;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                   lk_valid_q, lk_hit_q;
    logic [47:0]            lk_mac_q;

    // Fields shift in big-endian; they stay stable through the commit cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            htype_q  <= '0;
            ptype_q  <= '0;
            oper_q   <= '0;
            hlen_q   <= '0;
            plen_q   <= '0;
            sha_q    <= '0;
            spa_q    <= '0;
            tpa_q    <= '0;
            commit_q <= 1'b0;
            len_ok_q <= 1'b0;
        end else begin
            commit_q <= arp_tvalid_in && arp_tlast_in;
            if (arp_tvalid_in) begin
                len_ok_q <= (cnt_q >= 6'd27);
                if (arp_tlast_in)
                    cnt_q <= '0;
                else if (cnt_q != 6'd63)
                    cnt_q <= cnt_q + 6'd1;
                case (cnt_q)
                    6'd0, 6'd1:                      htype_q <= {htype_q[7:0], arp_tdata_in};
                    6'd2, 6'd3:                      ptype_q <= {ptype_q[7:0], arp_tdata_in};
                    6'd4:                            hlen_q  <= arp_tdata_in;
                    6'd5:                            plen_q  <= arp_tdata_in;
                    6'd6, 6'd7:                      oper_q  <= {oper_q[7:0], arp_tdata_in};
                    6'd8, 6'd9, 6'd10, 6'd11,
                    6'd12, 6'd13:                    sha_q   <= {sha_q[39:0], arp_tdata_in};
                    6'd14, 6'd15, 6'd16, 6'd17:      spa_q   <= {spa_q[23:0], arp_tdata_in};
                    6'd24, 6'd25, 6'd26, 6'd27:      tpa_q   <= {tpa_q[23:0], arp_tdata_in};
                    default: ;
                endcase
            end
        end
    end

    logic good, tpa_local, reply_qual, hs, learn_en, adv_rr;
    logic match_any, free_any, lk_hit;
    logic [PTR_W-1:0] match_idx, free_idx, wr_idx;
    logic [47:0] lk_mac;

    always_comb begin
        good = len_ok_q && htype_q == 16'h0001 && ptype_q == 16'h0800 &&
               hlen_q == 8'd6 && plen_q == 8'd4 && (oper_q == 16'd1 || oper_q == 16'd2);
        tpa_local  = (tpa_q == local_ip_addr);
        reply_qual = commit_q && good && oper_q == 16'd1 && tpa_local;
        hs         = reply_valid_q && reply_ready_in;
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        lk_hit    = 1'b0;
        lk_mac    = '0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            if (valid_q[i] && ip_q[i] == spa_q) begin
                match_any = 1'b1;
                match_idx = PTR_W'(i);
            end
            if (valid_q[i] && ip_q[i] == lookup_ip_in) begin
                lk_hit = 1'b1;
                lk_mac = mac_q[i];
            end
        end
        // Descending scan leaves the lowest-index free slot selected.
        for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
        learn_en = commit_q && good && spa_q != 32'd0 && (match_any || tpa_local);
        wr_idx   = match_any ? match_idx : (free_any ? free_idx : rr_q);
        adv_rr   = learn_en && !match_any && !free_any;
        drop_d   = drop_q;
        if (commit_q && (!good || (reply_qual && reply_valid_q && !hs)) && drop_q != '1)
            drop_d = drop_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
            end
        end else if (cache_clear_in) begin
            valid_q <= '0;
            rr_q    <= '0;
        end else if (learn_en) begin
            valid_q[wr_idx] <= 1'b1;
            ip_q[wr_idx]    <= spa_q;
            mac_q[wr_idx]   <= sha_q;
            if (adv_rr)
                rr_q <= (rr_q == PTR_W'(CACHE_DEPTH - 1)) ? '0 : rr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reply_valid_q <= 1'b0;
            reply_ip_q    <= '0;
            reply_mac_q   <= '0;
            drop_q        <= '0;
            lk_valid_q    <= 1'b0;
            lk_hit_q      <= 1'b0;
            lk_mac_q      <= '0;
        end else begin
            drop_q <= drop_d;
            if (reply_qual && (!reply_valid_q || hs)) begin
                reply_valid_q <= 1'b1;
                reply_ip_q    <= spa_q;
                reply_mac_q   <= sha_q;
            end else if (hs) begin
                reply_valid_q <= 1'b0;
            end
            lk_valid_q <= lookup_req_in;
            lk_hit_q   <= lookup_req_in && lk_hit;
            lk_mac_q   <= (lookup_req_in && lk_hit) ? lk_mac : 48'd0;
        end
    end

    assign reply_valid_out  = reply_valid_q;
    assign reply_ip_out     = reply_ip_q;
    assign reply_mac_out    = reply_mac_q;
    assign lookup_valid_out = lk_valid_q;
    assign lookup_hit_out   = lk_hit_q;
    assign lookup_mac_out   = lk_mac_q;
    assign drop_cnt_out     = drop_q;
endmodule

// File: tb/tb_arp_rx_cache.sv
// tb/tb_arp_rx_cache.sv - scoreboard bench for arp_rx_cache
module tb_arp_rx_cache;
    localparam logic [31:0] LOCAL = 32'hC0A8010A;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  arp_tdata_in;
    logic        arp_tvalid_in, arp_tlast_in;
    logic [31:0] local_ip_addr;
    logic        cache_clear_in;
    logic        reply_valid_out, reply_ready_in;
    logic [31:0] reply_ip_out;
    logic [47:0] reply_mac_out;
    logic        lookup_req_in;
    logic [31:0] lookup_ip_in;
    logic        lookup_valid_out, lookup_hit_out;
    logic [47:0] lookup_mac_out;
    logic [15:0] drop_cnt_out;

    arp_rx_cache #(.CACHE_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .arp_tdata_in(arp_tdata_in), .arp_tvalid_in(arp_tvalid_in), .arp_tlast_in(arp_tlast_in),
        .local_ip_addr(local_ip_addr), .cache_clear_in(cache_clear_in),
        .reply_valid_out(reply_valid_out), .reply_ready_in(reply_ready_in),
        .reply_ip_out(reply_ip_out), .reply_mac_out(reply_mac_out),
        .lookup_req_in(lookup_req_in), .lookup_ip_in(lookup_ip_in),
        .lookup_valid_out(lookup_valid_out), .lookup_hit_out(lookup_hit_out),
        .lookup_mac_out(lookup_mac_out), .drop_cnt_out(drop_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; logic [47:0] exp; } chk_t;
    chk_t        chk_q   [$];
    logic [79:0] exp_rep [$];
    logic [48:0] exp_lk  [$];
    logic [7:0]  frame_buf [64];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        done  = 1'b0;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        chk_t c;
        logic [79:0] e;
        cyc++;
        if (cyc > 20000) begin
            total++;
            bad++;
            $display("FAIL watchdog: got cycle %0d want done", cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (reset_n && lookup_valid_out) begin
            if (exp_lk.size() == 0) check("unexpected_lookup", 80'd1, 80'd0);
            else begin
                e = {31'd0, exp_lk.pop_front()};
                check("lookup", {31'd0, lookup_hit_out, lookup_mac_out}, e);
            end
        end
        if (reset_n && reply_valid_out && reply_ready_in) begin
            if (exp_rep.size() == 0) check("unexpected_reply", 80'd1, 80'd0);
            else check("reply", {reply_ip_out, reply_mac_out}, exp_rep.pop_front());
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                0:       check("drop_cnt", {64'd0, drop_cnt_out}, {32'd0, c.exp});
                1:       check("reply_valid", {79'd0, reply_valid_out}, {32'd0, c.exp});
                default: check("reply_ip_hold", {48'd0, reply_ip_out}, {32'd0, c.exp});
            endcase
        end
        if (done) begin
            check("reply_queue_drained", 80'(exp_rep.size()), 80'd0);
            check("lookup_queue_drained", 80'(exp_lk.size()), 80'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int kind, input logic [47:0] v);
        chk_q.push_back('{kind, v});
    endtask

    task automatic fill(input logic [15:0] ptype, input logic [15:0] oper, input logic [47:0] sha,
                        input logic [31:0] spa, input logic [31:0] tpa);
        logic [223:0] hdr;
        hdr = {16'h0001, ptype, 8'd6, 8'd4, oper, sha, spa, 48'd0, tpa};
        for (int i = 0; i < 64; i++) frame_buf[i] = (i < 28) ? hdr[223 - 8*i -: 8] : 8'h00;
    endtask

    task automatic send(input int len, input int stall_at);
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                arp_tvalid_in = 1'b0;
                arp_tdata_in  = 8'hFF;
                tick();
                tick();
            end
            arp_tdata_in  = frame_buf[i];
            arp_tvalid_in = 1'b1;
            arp_tlast_in  = (i == len - 1);
            tick();
        end
        arp_tvalid_in = 1'b0;
        arp_tlast_in  = 1'b0;
        arp_tdata_in  = 8'h00;
    endtask

    task automatic lookup(input logic [31:0] ip, input logic hit, input logic [47:0] mac);
        lookup_req_in = 1'b1;
        lookup_ip_in  = ip;
        exp_lk.push_back({hit, mac});
        tick();
    endtask

    task automatic lookup_end();
        lookup_req_in = 1'b0;
        tick();
    endtask

    initial begin
        reset_n = 1'b0; arp_tdata_in = '0; arp_tvalid_in = 1'b0; arp_tlast_in = 1'b0;
        local_ip_addr = LOCAL; cache_clear_in = 1'b0; reply_ready_in = 1'b0;
        lookup_req_in = 1'b0; lookup_ip_in = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        expect_now(0, 48'd0);
        expect_now(1, 48'd0);
        lookup(32'hC0A80114, 1'b0, 48'd0);
        lookup_end();

        // Request to us with a stall inside SPA: reply on tlast+2, held until ready.
        fill(16'h0800, 16'd1, 48'h000A35010203, 32'hC0A80114, LOCAL);
        exp_rep.push_back({32'hC0A80114, 48'h000A35010203});
        send(28, 15);
        expect_now(1, 48'd0);
        tick();
        expect_now(1, 48'd1);
        expect_now(2, 48'hC0A80114);
        tick();
        tick();
        expect_now(1, 48'd1);
        expect_now(2, 48'hC0A80114);
        reply_ready_in = 1'b1;
        tick();
        expect_now(1, 48'd0);
        lookup(32'hC0A80114, 1'b1, 48'h000A35010203);
        lookup_end();

        // Request for another host: neither reply nor learn.
        fill(16'h0800, 16'd1, 48'h000A35AAAAAA, 32'hC0A80199, 32'hC0A80163);
        send(28, -1);
        repeat (3) tick();
        expect_now(1, 48'd0);
        expect_now(0, 48'd0);
        lookup(32'hC0A80199, 1'b0, 48'd0);
        lookup_end();

        // Wrong PTYPE, then a runt frame.
        fill(16'h86DD, 16'd1, 48'h000A35BBBBBB, 32'hC0A8014D, LOCAL);
        send(28, -1);
        tick();
        fill(16'h0800, 16'd1, 48'h000A35CCCCCC, 32'hC0A8014E, LOCAL);
        send(20, -1);
        repeat (3) tick();
        expect_now(0, 48'd2);
        expect_now(1, 48'd0);
        lookup(32'hC0A8014D, 1'b0, 48'd0);
        lookup(32'hC0A8014E, 1'b0, 48'd0);
        lookup(32'hC0A80114, 1'b1, 48'h000A35010203);
        lookup_end();

        // Fill all four entries and one more: entry 0 evicted by round robin.
        cache_clear_in = 1'b1;
        tick();
        cache_clear_in = 1'b0;
        lookup(32'hC0A80114, 1'b0, 48'd0);
        lookup_end();
        for (int k = 0; k < 5; k++) begin
            fill(16'h0800, 16'd1, 48'h020000000010 + 48'(k), 32'hC0A8011F + 32'(k), LOCAL);
            exp_rep.push_back({32'hC0A8011F + 32'(k), 48'h020000000010 + 48'(k)});
            send(28, -1);
            repeat (3) tick();
        end
        lookup(32'hC0A8011F, 1'b0, 48'd0);
        lookup(32'hC0A80123, 1'b1, 48'h020000000014);
        lookup(32'hC0A80120, 1'b1, 48'h020000000011);
        lookup_end();

        // Two replies while TX is stalled: second dropped, both learned.
        reply_ready_in = 1'b0;
        fill(16'h0800, 16'd1, 48'h0200000000A1, 32'hC0A80129, LOCAL);
        exp_rep.push_back({32'hC0A80129, 48'h0200000000A1});
        send(28, -1);
        tick();
        fill(16'h0800, 16'd1, 48'h0200000000A2, 32'hC0A8012A, LOCAL);
        send(28, -1);
        tick();
        tick();
        expect_now(0, 48'd3);
        expect_now(1, 48'd1);
        expect_now(2, 48'hC0A80129);
        lookup(32'hC0A80129, 1'b1, 48'h0200000000A1);
        lookup(32'hC0A8012A, 1'b1, 48'h0200000000A2);
        lookup(32'hC0A80120, 1'b0, 48'd0);
        lookup(32'hC0A80123, 1'b1, 48'h020000000014);
        lookup_end();
        reply_ready_in = 1'b1;
        tick();
        expect_now(1, 48'd0);

        // Clear on the commit cycle of a padded 34-byte learning frame.
        fill(16'h0800, 16'd1, 48'h0200000000B1, 32'hC0A80133, LOCAL);
        exp_rep.push_back({32'hC0A80133, 48'h0200000000B1});
        send(34, -1);
        cache_clear_in = 1'b1;
        tick();
        cache_clear_in = 1'b0;
        tick();
        lookup(32'hC0A80133, 1'b0, 48'd0);
        lookup(32'hC0A80123, 1'b0, 48'd0);
        lookup(32'hC0A80129, 1'b0, 48'd0);
        lookup_end();
        expect_now(0, 48'd3);
        expect_now(1, 48'd0);
        repeat (2) tick();
        done = 1'b1;
        repeat (4) tick();
    end
endmodule
